// File: rtl/id_decode_stage.sv
// id_decode_stage: registered RV32I/RV64I decode stage with valid/ready flow control, flush and event counters
module id_decode_stage #(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             id_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [2:0]       func3,
    output logic [6:0]       func7,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [XLEN-1:0]  imm_out,
    output logic [5:0]       fmt,
    output logic             rs1_used,
    output logic             rs2_used,
    output logic             illegal,
    output logic [CNT_W-1:0] decoded_cnt,
    output logic [CNT_W-1:0] flushed_cnt
);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic s;
    logic is_opimm, is_load, is_jalr, is_s, is_b, is_j, is_u, is_r, is_fence, is_sys;
    logic is_i, known, r_bad, ill, load;
    logic signed [31:0] imm32;
    logic [XLEN-1:0] imm_d;
    logic [5:0] fmt_d;
    logic rs1_d, rs2_d;

    always_comb begin
        op       = in_instr[6:0];
        f3       = in_instr[14:12];
        f7       = in_instr[31:25];
        s        = in_instr[31];
        is_opimm = op == 7'b0010011;
        is_load  = op == 7'b0000011;
        is_jalr  = op == 7'b1100111;
        is_s     = op == 7'b0100011;
        is_b     = op == 7'b1100011;
        is_j     = op == 7'b1101111;
        is_u     = op == 7'b0110111 || op == 7'b0010111;
        is_r     = op == 7'b0110011;
        is_fence = op == 7'b0001111;
        is_sys   = op == 7'b1110011;
        is_i     = is_opimm | is_load | is_jalr;
        known    = is_i | is_s | is_b | is_j | is_u | is_r | is_fence | is_sys;
        r_bad    = is_r && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
                             || (ENABLE_M != 0 && f7 == 7'h01));
        ill      = in_instr[1:0] != 2'b11 || !known || r_bad;
        imm32    = is_i ? {{20{s}}, in_instr[31:20]} :
                   is_s ? {{20{s}}, in_instr[31:25], in_instr[11:7]} :
                   is_b ? {{19{s}}, s, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                   is_j ? {{11{s}}, s, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                   is_u ? {in_instr[31:12], 12'b0} : 32'sd0;
        // 32-bit form is sign-extended so U-type also extends on RV64
        imm_d    = ill ? '0 : XLEN'(imm32);
        fmt_d    = ill ? 6'b0 : {is_j, is_u, is_b, is_s, is_i | is_fence | is_sys, is_r};
        rs1_d    = !ill && (is_r | is_i | is_sys | is_s | is_b);
        rs2_d    = !ill && (is_r | is_s | is_b);
        in_ready = !out_valid || out_ready;
        load     = in_valid && in_ready && !id_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            opcode      <= '0;
            func3       <= '0;
            func7       <= '0;
            rd          <= '0;
            rs1         <= '0;
            rs2         <= '0;
            imm_out     <= '0;
            fmt         <= '0;
            rs1_used    <= 1'b0;
            rs2_used    <= 1'b0;
            illegal     <= 1'b0;
            decoded_cnt <= '0;
            flushed_cnt <= '0;
        end else if (id_flush) begin
            out_valid <= 1'b0;
            if (out_valid) flushed_cnt <= flushed_cnt + 1'b1;
        end else begin
            if (out_valid && out_ready) decoded_cnt <= decoded_cnt + 1'b1;
            if (load) begin
                out_valid <= 1'b1;
                out_pc    <= in_pc;
                opcode    <= op;
                func3     <= f3;
                func7     <= f7;
                rd        <= in_instr[11:7];
                rs1       <= in_instr[19:15];
                rs2       <= in_instr[24:20];
                imm_out   <= imm_d;
                fmt       <= fmt_d;
                rs1_used  <= rs1_d;
                rs2_used  <= rs2_d;
                illegal   <= ill;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed checks of decode, flow control, flush and async reset on RV32 and RV64+M instances
module tb_id_decode_stage;
    logic clk = 0, rst = 1, in_valid = 0, id_flush = 0, out_ready = 1;
    logic [31:0] in_instr = 0;
    logic [63:0] pc = 0;
    int checks = 0, errors = 0;

    logic a_in_ready, a_out_valid, a_rs1u, a_rs2u, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [6:0] a_op, a_f7;
    logic [2:0] a_f3;
    logic [4:0] a_rd, a_rs1, a_rs2;
    logic [5:0] a_fmt;
    logic [15:0] a_dec, a_fl;

    logic b_in_ready, b_out_valid, b_rs1u, b_rs2u, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [6:0] b_op, b_f7;
    logic [2:0] b_f3;
    logic [4:0] b_rd, b_rs1, b_rs2;
    logic [5:0] b_fmt;
    logic [15:0] b_dec, b_fl;

    id_decode_stage #(.XLEN(32), .ENABLE_M(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
        .in_pc(pc[31:0]), .id_flush(id_flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .opcode(a_op), .func3(a_f3), .func7(a_f7), .rd(a_rd), .rs1(a_rs1),
        .rs2(a_rs2), .imm_out(a_imm), .fmt(a_fmt), .rs1_used(a_rs1u), .rs2_used(a_rs2u),
        .illegal(a_ill), .decoded_cnt(a_dec), .flushed_cnt(a_fl));

    id_decode_stage #(.XLEN(64), .ENABLE_M(1), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
        .in_pc(pc), .id_flush(id_flush), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .opcode(b_op), .func3(b_f3), .func7(b_f7), .rd(b_rd), .rs1(b_rs1),
        .rs2(b_rs2), .imm_out(b_imm), .fmt(b_fmt), .rs1_used(b_rs1u), .rs2_used(b_rs2u),
        .illegal(b_ill), .decoded_cnt(b_dec), .flushed_cnt(b_fl));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1;
        in_instr = w;
        step();
        in_valid = 0;
    endtask

    initial begin
        #1;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_ready", a_in_ready, 1);
        chk("rst_dec", a_dec, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_fmt", a_fmt, 0);
        #13 rst = 0;
        step();

        pc = 64'h1000;
        send(32'hFFF10093);
        chk("addi_valid", a_out_valid, 1);
        chk("addi_pc", a_pc, 32'h1000);
        chk("addi_op", a_op, 7'h13);
        chk("addi_rd", a_rd, 1);
        chk("addi_rs1", a_rs1, 2);
        chk("addi_imm", a_imm, 32'hFFFFFFFF);
        chk("addi_imm64", b_imm, 64'hFFFFFFFFFFFFFFFF);
        chk("addi_fmt", a_fmt, 6'b000010);
        chk("addi_rs1u", a_rs1u, 1);
        chk("addi_rs2u", a_rs2u, 0);
        chk("addi_dec", a_dec, 0);

        send(32'h00512423);
        chk("sw_dec", a_dec, 1);
        chk("sw_imm", a_imm, 8);
        chk("sw_fmt", a_fmt, 6'b000100);
        chk("sw_rs2", a_rs2, 5);
        chk("sw_rs2u", a_rs2u, 1);

        send(32'hFE000EE3);
        chk("beq_imm", a_imm, 32'hFFFFFFFC);
        chk("beq_fmt", a_fmt, 6'b001000);

        send(32'h123451B7);
        chk("lui_imm", a_imm, 32'h12345000);
        chk("lui_imm64", b_imm, 64'h12345000);
        chk("lui_fmt", a_fmt, 6'b010000);
        chk("lui_rs1u", a_rs1u, 0);

        send(32'h800000B7);
        chk("lui_neg", a_imm, 32'h80000000);
        chk("lui_neg64", b_imm, 64'hFFFFFFFF80000000);

        send(32'hFFFFFFFF);
        chk("ones_ill", a_ill, 1);
        chk("ones_fmt", a_fmt, 0);
        chk("ones_imm", a_imm, 0);
        chk("ones_valid", a_out_valid, 1);

        send(32'h00000000);
        chk("zero_ill", a_ill, 1);
        chk("zero_fmt", a_fmt, 0);
        chk("zero_valid", a_out_valid, 1);

        send(32'h02208033);
        chk("mul_ill", a_ill, 1);
        chk("mul_fmt", a_fmt, 0);
        chk("mul_rs1u", a_rs1u, 0);
        chk("mulm_ill", b_ill, 0);
        chk("mulm_fmt", b_fmt, 6'b000001);
        chk("mulm_rs2u", b_rs2u, 1);

        send(32'h008000EF);
        chk("jal_imm", a_imm, 8);
        chk("jal_fmt", a_fmt, 6'b100000);
        chk("jal_rs1u", a_rs1u, 0);

        step();
        chk("drain_valid", a_out_valid, 0);
        chk("drain_dec", a_dec, 9);

        out_ready = 0;
        send(32'h00100093);
        in_valid = 1;
        in_instr = 32'h00200113;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", a_in_ready, 0);
            chk("bp_valid", a_out_valid, 1);
            chk("bp_rd", a_rd, 1);
            chk("bp_imm", a_imm, 1);
            chk("bp_dec", a_dec, 9);
        end
        out_ready = 1;
        #1;
        chk("rel_ready", a_in_ready, 1);
        step();
        in_valid = 0;
        chk("rel_rd", a_rd, 2);
        chk("rel_imm", a_imm, 2);
        chk("rel_valid", a_out_valid, 1);
        chk("rel_dec", a_dec, 10);
        step();
        chk("rel_drain", a_out_valid, 0);
        chk("rel_dec2", a_dec, 11);

        out_ready = 0;
        send(32'h00300193);
        chk("fl_pre", a_out_valid, 1);
        in_valid = 1;
        in_instr = 32'h00400213;
        id_flush = 1;
        step();
        id_flush = 0;
        in_valid = 0;
        out_ready = 1;
        chk("fl_valid", a_out_valid, 0);
        chk("fl_cnt", a_fl, 1);
        chk("fl_dec", a_dec, 11);
        step();
        chk("fl_gone", a_out_valid, 0);
        chk("fl_dec2", a_dec, 11);

        out_ready = 0;
        send(32'h00500293);
        chk("ar_pre", a_imm, 5);
        #2 rst = 1;
        #1;
        chk("ar_valid", a_out_valid, 0);
        chk("ar_dec", a_dec, 0);
        chk("ar_fl", a_fl, 0);
        chk("ar_imm", a_imm, 0);
        chk("ar_imm64", b_imm, 0);
        #2 rst = 0;
        step();
        chk("ar_ready", a_in_ready, 1);
        chk("ar_valid2", a_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
